input_debounce: RTL and testbench



---
 rtl/input_debounce_if.sv | 27 ++
 rtl/input_debounce.sv | 101 ++++++++++
 tb/tb_input_debounce.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/input_debounce_if.sv
// Debounce channel bundle: raw pad levels in, clean levels and edge pulses out.
// The pad/stimulus side is the master; the debouncer is the slave.
interface input_debounce_if #(
  parameter int N = 8
);
  logic [N-1:0] raw_in;
  logic [N-1:0] level;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         changed;

  modport master (
    output raw_in,
    input  level,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  raw_in,
    output level,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/input_debounce.sv
// N-channel switch/button debouncer: 2-flop sync plus per-channel stability counter.
// Edge pulses (rise/fall/changed) are built only when INPUT_DEBOUNCE_EDGE_EN is defined.
module input_debounce #(
  parameter int N             = 8,
  parameter int STABLE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input_debounce_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LP_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LP_ONE  = CW'(1);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_e;

  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic [N-1:0]  r_level;
  logic [CW-1:0] r_cnt [N];

  state_e        w_state   [N];
  logic [CW-1:0] w_cnt_nxt [N];
  logic [N-1:0]  w_level_nxt;
  logic [N-1:0]  w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_level <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= bus.raw_in;
      r_s2    <= r_s1;
      r_level <= w_level_nxt;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  // State is the mismatch between synced input and accepted level;
  // any return to the accepted level drops the partial count.
  always_comb begin
    w_level_nxt = r_level;
    w_accept    = '0;
    for (int i = 0; i < N; i++) begin
      w_state[i]   = (r_s2[i] != r_level[i]) ? ST_PENDING : ST_STABLE;
      w_cnt_nxt[i] = '0;
      unique case (w_state[i])
        ST_STABLE: begin
          w_cnt_nxt[i] = '0;
        end
        ST_PENDING: begin
          if (r_cnt[i] == LP_LAST) begin
            w_accept[i]    = 1'b1;
            w_level_nxt[i] = r_s2[i];
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + LP_ONE;
          end
        end
      endcase
    end
  end

  assign bus.level = r_level;

`ifdef INPUT_DEBOUNCE_EDGE_EN
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;
  logic         r_changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_accept & r_s2;
      r_fall    <= w_accept & ~r_s2;
      r_changed <= |w_accept;
    end
  end

  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.changed = r_changed;
`else
  assign bus.rise    = '0;
  assign bus.fall    = '0;
  assign bus.changed = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Bench for input_debounce: directed scenarios plus random holds,
// checked every cycle against a timestamp-based reference model.
module tb_input_debounce;

  localparam int N  = 8;
  localparam int SC = 16;
`ifdef INPUT_DEBOUNCE_EDGE_EN
  localparam int EDGE_EN = 1;
`else
  localparam int EDGE_EN = 0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] raw   = '0;

  always #5 clk = ~clk;

  input_debounce_if #(.N(N)) bus ();
  assign bus.raw_in = raw;

  input_debounce #(
    .N(N),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int e     = 0;

  logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
  int m_start [N];
  int rise_cnt [N];
  int fall_cnt [N];
  int chg_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_level = '0;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) m_start[i] = e;
  endtask

  // A new value is accepted once the synced input has held it,
  // differing from the level, for SC consecutive edges.
  task automatic model_edge();
    logic [N-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++)
      if (m_s2[i] != m_level[i] && (e - m_start[i]) == SC) acc[i] = 1'b1;
    m_rise  = acc & m_s2;
    m_fall  = acc & ~m_s2;
    m_level = m_level ^ acc;
    for (int i = 0; i < N; i++)
      if (m_s1[i] != m_s2[i]) m_start[i] = e;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    chg_cnt = 0;
  endtask

  task automatic compare_all();
    logic [N-1:0] xr, xf;
    logic         xc;
    xr = (EDGE_EN != 0) ? m_rise : '0;
    xf = (EDGE_EN != 0) ? m_fall : '0;
    xc = (EDGE_EN != 0) ? |(m_rise | m_fall) : 1'b0;
    chk("level", 32'(bus.level), 32'(m_level));
    chk("rise", 32'(bus.rise), 32'(xr));
    chk("fall", 32'(bus.fall), 32'(xf));
    chk("changed", 32'(bus.changed), 32'(xc));
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] += int'(bus.rise[i]);
      fall_cnt[i] += int'(bus.fall[i]);
    end
    chg_cnt += int'(bus.changed);
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic int sum_fall();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += fall_cnt[i];
    return s;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int p;
    clear_cnt();
    model_reset();
    #1;
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_rise", 32'(bus.rise), 32'h0);
    chk("rst_fall", 32'(bus.fall), 32'h0);
    chk("rst_changed", 32'(bus.changed), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();

    // clean press on channel 4
    clear_cnt();
    raw[4] = 1'b1;
    t0 = e;
    p = -1;
    repeat (30) begin
      tick();
      if (bus.level[4] && p < 0) p = e - t0;
    end
    chk("press_edge", p, 18);
    chk("press_rise", rise_cnt[4], EDGE_EN);
    chk("press_fall", sum_fall(), 0);
    chk("press_chg", chg_cnt, EDGE_EN);

    // bounce on channel 0
    raw = '0;
    repeat (25) tick();
    clear_cnt();
    raw[0] = 1'b1; repeat (10) tick();
    raw[0] = 1'b0; repeat (3) tick();
    raw[0] = 1'b1; repeat (10) tick();
    raw[0] = 1'b0; repeat (5) tick();
    chk("bounce_level", 32'(bus.level[0]), 32'h0);
    chk("bounce_rise", rise_cnt[0], 0);
    chk("bounce_chg", chg_cnt, 0);
    raw[0] = 1'b1;
    repeat (18) tick();
    chk("bounce_accept", 32'(bus.level[0]), 32'h1);
    chk("bounce_rise1", rise_cnt[0], EDGE_EN);

    // release and simultaneous events
    raw = 8'hF0;
    repeat (25) tick();
    chk("sim_pre", 32'(bus.level), 32'hF0);
    clear_cnt();
    raw = 8'h0F;
    repeat (17) tick();
    chk("sim_e17", 32'(bus.level), 32'hF0);
    tick();
    chk("sim_level", 32'(bus.level), 32'h0F);
    chk("sim_rise", 32'(bus.rise), (EDGE_EN != 0) ? 32'h0F : 32'h0);
    chk("sim_fall", 32'(bus.fall), (EDGE_EN != 0) ? 32'hF0 : 32'h0);
    chk("sim_chg", 32'(bus.changed), 32'(EDGE_EN));
    tick();
    chk("sim_chg_off", 32'(bus.changed), 32'h0);

    // reset mid-count
    raw = 8'h81;
    repeat (25) tick();
    raw = 8'h85;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_level", 32'(bus.level), 32'h0);
    chk("arst_rise", 32'(bus.rise), 32'h0);
    chk("arst_fall", 32'(bus.fall), 32'h0);
    chk("arst_chg", 32'(bus.changed), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    t0 = e;
    p = -1;
    repeat (25) begin
      tick();
      if (bus.level[2] && p < 0) p = e - t0;
    end
    chk("rst_requal", p, 18);

    // random holds and toggles
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 1) == 1) raw = N'($urandom);
      else raw = raw ^ (N'(1) << $urandom_range(0, N - 1));
      repeat ($urandom_range(1, 24)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
